// File: rtl/pipe_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_step_ctrl
//  Description : Pipeline clock-enable controller with free-run / single-step
//                modes and load-use hazard stalling. Build option
//                PIPE_STEP_CTRL_HAZARD_STALL_EN enables hazard detection
//                and the stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_step_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        pause,
    input  logic        step_down,
    input  logic        idex_memread,
    input  logic [3:0]  idex_wa,
    input  logic [3:0]  ifid_ra1,
    input  logic [3:0]  ifid_ra2,
    output logic        advance,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_bubble,
    output logic [1:0]  state,
    output logic [15:0] cycle_cnt,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        c_ST_RUN    = 2'b00,
        c_ST_PAUSED = 2'b01,
        c_ST_STEP   = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_adv_ok;
    logic        w_hazard;
    logic [15:0] r_cycle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A step press is only honoured from PAUSED; pause release always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_adv_ok    = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                w_adv_ok = tick & ~pause;
                if (pause) w_state_nxt = c_ST_PAUSED;
            end
            c_ST_PAUSED: begin
                if (!pause)         w_state_nxt = c_ST_RUN;
                else if (step_down) w_state_nxt = c_ST_STEP;
            end
            c_ST_STEP: begin
                w_adv_ok = tick;
                if (!pause)    w_state_nxt = c_ST_RUN;
                else if (tick) w_state_nxt = c_ST_PAUSED;
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
    end

    // Gate with rst_n so enables drop immediately while reset is held.
    assign advance     = w_adv_ok & rst_n;
    assign pc_en       = advance & ~w_hazard;
    assign ifid_en     = advance & ~w_hazard;
    assign idex_bubble = advance & w_hazard;
    assign state       = r_state;
    assign cycle_cnt   = r_cycle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= 16'h0000;
        end else if (advance) begin
            r_cycle_cnt <= r_cycle_cnt + 16'h0001;
        end
    end

`ifdef PIPE_STEP_CTRL_HAZARD_STALL_EN
    logic [15:0] r_stall_cnt;

    assign w_hazard  = idex_memread & ((idex_wa == ifid_ra1) | (idex_wa == ifid_ra2));
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (idex_bubble && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end
`else
    logic w_unused_hazard_inputs;

    assign w_hazard               = 1'b0;
    assign stall_cnt              = 16'h0000;
    assign w_unused_hazard_inputs = &{1'b0, idex_memread, idex_wa, ifid_ra1, ifid_ra2};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_step_ctrl
//  Description : Self-checking bench for pipe_step_ctrl (directed + random).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_step_ctrl;

`ifdef PIPE_STEP_CTRL_HAZARD_STALL_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0, pause = 1'b0, step_down = 1'b0, idex_memread = 1'b0;
    logic [3:0]  idex_wa = 4'd0, ifid_ra1 = 4'd0, ifid_ra2 = 4'd0;
    logic        advance, pc_en, ifid_en, idex_bubble;
    logic [1:0]  state;
    logic [15:0] cycle_cnt, stall_cnt;

    int n_checks = 0;
    int n_err    = 0;

    pipe_step_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .pause(pause), .step_down(step_down),
        .idex_memread(idex_memread), .idex_wa(idex_wa), .ifid_ra1(ifid_ra1),
        .ifid_ra2(ifid_ra2), .advance(advance), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_bubble(idex_bubble), .state(state), .cycle_cnt(cycle_cnt),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = running, 1 = paused, 2 = one step armed.
    int m_mode  = 0;
    int m_cyc   = 0;
    int m_stall = 0;

    function automatic bit m_adv();
        return rst_n && tick && ((m_mode == 0 && !pause) || m_mode == 2);
    endfunction

    function automatic bit m_hz();
        return HZ && idex_memread && (idex_wa == ifid_ra1 || idex_wa == ifid_ra2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= 0;
            m_cyc   <= 0;
            m_stall <= 0;
        end else begin
            if (m_adv()) m_cyc <= (m_cyc + 1) % 65536;
            if (m_adv() && m_hz() && m_stall < 65535) m_stall <= m_stall + 1;
            if (m_mode == 0 && pause)                  m_mode <= 1;
            else if (m_mode == 1 && !pause)            m_mode <= 0;
            else if (m_mode == 1 && step_down)         m_mode <= 2;
            else if (m_mode == 2 && !pause)            m_mode <= 0;
            else if (m_mode == 2 && tick)              m_mode <= 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("advance",     {31'd0, advance},     {31'd0, m_adv()});
        chk("pc_en",       {31'd0, pc_en},       {31'd0, m_adv() && !m_hz()});
        chk("ifid_en",     {31'd0, ifid_en},     {31'd0, m_adv() && !m_hz()});
        chk("idex_bubble", {31'd0, idex_bubble}, {31'd0, m_adv() && m_hz()});
        chk("state",       {30'd0, state},       m_mode);
        chk("cycle_cnt",   {16'd0, cycle_cnt},   m_cyc);
        chk("stall_cnt",   {16'd0, stall_cnt},   m_stall);
    end

    task automatic drv(input logic t, input logic p, input logic s, input logic m,
                       input logic [3:0] wa, input logic [3:0] r1, input logic [3:0] r2);
        tick = t; pause = p; step_down = s; idex_memread = m;
        idex_wa = wa; ifid_ra1 = r1; ifid_ra2 = r2;
        #2;
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        step_clk();
        rst_n = 1'b1;
    endtask

    logic [15:0] base;

    initial begin
        // Reset values while rst_n held low
        repeat (3) step_clk();
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_cycle", {16'd0, cycle_cnt}, 32'd0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
        rst_n = 1'b1;

        // Free run: five ticks, five advances
        for (int i = 0; i < 5; i++) begin
            drv(1, 0, 0, 0, 0, 0, 0);
            chk("run_adv", {31'd0, advance}, 32'd1);
            step_clk();
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("run_idle_adv", {31'd0, advance}, 32'd0);
        chk("run_cycle5", {16'd0, cycle_cnt}, 32'd5);
        chk("run_state", {30'd0, state}, 32'd0);

        // Pause with a coincident tick: that advance is suppressed
        drv(1, 1, 0, 0, 0, 0, 0);
        chk("pause_adv", {31'd0, advance}, 32'd0);
        step_clk();
        chk("paused_state", {30'd0, state}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 0, 0, 0, 0, 0); step_clk();
            drv(0, 1, 0, 0, 0, 0, 0); step_clk();
        end
        chk("paused_cycle", {16'd0, cycle_cnt}, 32'd5);
        drv(0, 1, 1, 0, 0, 0, 0); step_clk();
        chk("step_state", {30'd0, state}, 32'd2);
        drv(0, 1, 0, 0, 0, 0, 0); step_clk();
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 0, 0, 0, 0, 0);
            chk("step_adv", {31'd0, advance}, (i == 0) ? 32'd1 : 32'd0);
            step_clk();
            chk("step_after_state", {30'd0, state}, 32'd1);
            drv(0, 1, 0, 0, 0, 0, 0); step_clk();
        end
        chk("step_cycle", {16'd0, cycle_cnt}, 32'd6);

        // Step press and pause release together: back to free run
        drv(0, 0, 1, 0, 0, 0, 0); step_clk();
        chk("resume_state", {30'd0, state}, 32'd0);
        drv(1, 0, 0, 0, 0, 0, 0);
        chk("resume_adv", {31'd0, advance}, 32'd1);
        step_clk();
        drv(1, 0, 1, 0, 0, 0, 0);
        step_clk();
        chk("resume_cycle", {16'd0, cycle_cnt}, 32'd8);
        chk("run_ignores_step", {30'd0, state}, 32'd0);

        // Load-use hazard on ra2, then a non-matching destination
        drv(1, 0, 0, 1, 4'd3, 4'd0, 4'd3);
        chk("hz_adv", {31'd0, advance}, 32'd1);
        chk("hz_pc_en", {31'd0, pc_en}, HZ ? 32'd0 : 32'd1);
        chk("hz_ifid_en", {31'd0, ifid_en}, HZ ? 32'd0 : 32'd1);
        chk("hz_bubble", {31'd0, idex_bubble}, HZ ? 32'd1 : 32'd0);
        step_clk();
        chk("hz_stall_cnt", {16'd0, stall_cnt}, HZ ? 32'd1 : 32'd0);
        drv(1, 0, 0, 1, 4'd4, 4'd0, 4'd3);
        chk("nohz_pc_en", {31'd0, pc_en}, 32'd1);
        chk("nohz_bubble", {31'd0, idex_bubble}, 32'd0);
        step_clk();
        chk("nohz_stall_cnt", {16'd0, stall_cnt}, HZ ? 32'd1 : 32'd0);

        // Async reset mid-step, between clock edges
        drv(0, 1, 0, 0, 0, 0, 0); step_clk();
        drv(0, 1, 1, 0, 0, 0, 0); step_clk();
        chk("pre_rst_step", {30'd0, state}, 32'd2);
        drv(1, 1, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_cycle", {16'd0, cycle_cnt}, 32'd0);
        chk("arst_adv", {31'd0, advance}, 32'd0);
        step_clk();
        #2 rst_n = 1'b1;
        drv(1, 1, 0, 0, 0, 0, 0);
        chk("post_rst_pause_adv", {31'd0, advance}, 32'd0);
        step_clk();
        drv(0, 0, 0, 0, 0, 0, 0); step_clk();
        drv(1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_run_adv", {31'd0, advance}, 32'd1);
        step_clk();

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            drv($urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? ~pause : pause,
                ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
                4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
            step_clk();
        end

        // Counter wrap and stall saturation
        do_reset();
        drv(1, 0, 0, 1, 4'd5, 4'd5, 4'd0);
        base = cycle_cnt;
        chk("wrap_base", {16'd0, base}, 32'd0);
        repeat (65535) step_clk();
        chk("wrap_ffff", {16'd0, cycle_cnt}, 32'hFFFF);
        chk("sat_ffff", {16'd0, stall_cnt}, HZ ? 32'hFFFF : 32'd0);
        step_clk();
        chk("wrap_zero", {16'd0, cycle_cnt}, 32'd0);
        chk("sat_hold", {16'd0, stall_cnt}, HZ ? 32'hFFFF : 32'd0);
        drv(0, 0, 0, 0, 0, 0, 0);
        step_clk();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
